seq_player: RTL and testbench

Programmable serial pattern controller. It holds an LEN-bit pattern register and plays it onto Z one bit per CLK, MSB first, with a repeat count. It provides a START/STOP/LOAD command interface and BUSY/DONE status. Lab test sequences are driven through this block, so the target pattern can be changed or replayed without editing RTL.

---
 rtl/seq_player.sv | 131 +++++++++++++
 tb/tb_seq_player.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_player.sv
// Programmable serial pattern player. Plays a LEN-bit pattern MSB first onto Z
// with a repeat count, under START/STOP/LOAD control, reporting BUSY/DONE.
module seq_player #(
  parameter int              LEN = 10,
  parameter logic [LEN-1:0]  PAT = 10'b1101000101
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           START,
  input  logic           STOP,
  input  logic           LOAD,
  input  logic [LEN-1:0] PAT_IN,
  input  logic [3:0]     REPS,
  output logic           Z,
  output logic           VALID,
  output logic [3:0]     IDX,
  output logic           BUSY,
  output logic           DONE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(LEN - 1);
  localparam logic [4:0] LEN_W    = 5'(LEN);

  state_t         state_q, state_d;
  logic [LEN-1:0] pat_q, pat_d;
  logic [3:0]     idx_q, idx_d;
  logic [3:0]     rep_q, rep_d;
  logic           z_q, z_d;
  logic           valid_q, valid_d;
  logic [3:0]     idx_out_q, idx_out_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [LEN-1:0] shifted;

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    z_d       = 1'b0;
    valid_d   = 1'b0;
    idx_out_d = 4'd0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    // Current bit is always the MSB of the pattern shifted by the bit index.
    shifted   = pat_q << idx_q;

    case (state_q)
      IDLE: begin
        idx_d = 4'd0;
        if (LOAD) begin
          pat_d = PAT_IN;
        end else if (START) begin
          state_d = RUN;
          rep_d   = REPS;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (STOP) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          idx_d   = 4'd0;
        end else if ({1'b0, idx_q} >= LEN_W) begin
          idx_d = 4'd0;
        end else begin
          z_d       = shifted[LEN-1];
          valid_d   = 1'b1;
          idx_out_d = idx_q;
          if (idx_q == LAST_IDX) begin
            idx_d = 4'd0;
            // rep_q == 0 means continuous playback: never count down.
            if (rep_q == 4'd1) begin
              state_d = FIN;
            end else if (rep_q > 4'd1) begin
              rep_d = rep_q - 4'd1;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      pat_q     <= PAT;
      idx_q     <= 4'd0;
      rep_q     <= 4'd0;
      z_q       <= 1'b0;
      valid_q   <= 1'b0;
      idx_out_q <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      z_q       <= z_d;
      valid_q   <= valid_d;
      idx_out_q <= idx_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Z     = z_q;
  assign VALID = valid_q;
  assign IDX   = idx_out_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_seq_player.sv
// Scoreboard bench for seq_player: the driver pushes the expected bit/DONE stream
// (with the cycle it must appear) when it issues a run; a monitor pops and compares.
module tb_seq_player;

  localparam int              LEN = 10;
  localparam logic [LEN-1:0]  PAT = 10'b1101000101;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           stop;
  logic           load;
  logic [LEN-1:0] pat_in;
  logic [3:0]     reps;
  logic           z;
  logic           valid;
  logic [3:0]     idx;
  logic           busy;
  logic           done;

  seq_player #(.LEN(LEN), .PAT(PAT)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .STOP(stop), .LOAD(load),
    .PAT_IN(pat_in), .REPS(reps), .Z(z), .VALID(valid), .IDX(idx),
    .BUSY(busy), .DONE(done)
  );

  typedef struct {
    int cyc;
    bit is_done;
    bit zb;
    int ix;
  } exp_t;

  exp_t           exp_q[$];
  int             cyc = 0;
  int             n_checks = 0;
  int             n_fail = 0;
  logic [LEN-1:0] pat_m;
  bit             mon_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: bit i of a run is pattern bit LEN-1-(i mod LEN), shown at k+1+i.
  task automatic push_bits(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.cyc = k + 1 + i; e.is_done = 0; e.ix = i % LEN;
      e.zb = pat_m[LEN - 1 - (i % LEN)];
      exp_q.push_back(e);
    end
  endtask

  task automatic push_done(input int c);
    exp_t e;
    e.cyc = c; e.is_done = 1; e.zb = 0; e.ix = 0;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every presented bit / DONE pulse against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy_done_excl", int'(busy & done), 0);
      if (valid || done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_cycle", cyc, e.cyc);
          check("out_done", int'(done), int'(e.is_done));
          check("out_valid", int'(valid), int'(!e.is_done));
          check("out_z", int'(z), int'(e.zb));
          check("out_idx", int'(idx), e.ix);
          if (!e.is_done) check("busy_while_valid", int'(busy), 1);
        end
      end else begin
        check("z_quiet", int'(z), 0);
        check("idx_quiet", int'(idx), 0);
      end
    end
  end

  task automatic clear_noise();
    start = 0; load = 0; stop = 0;
  endtask

  // Plays one run; stop_after < 0 lets a finite run complete (ends in DONE cycle).
  task automatic play(input int r, input int stop_after, input bit noise);
    int k, total;
    k = cyc + 1;
    reps = 4'(r); start = 1; load = 0; stop = 0;
    tick();
    start = 0;
    check("busy_after_start", int'(busy), 1);
    total = (stop_after < 0) ? LEN * r : stop_after;
    push_bits(k, total);
    if (stop_after < 0) push_done(k + total + 1);
    for (int i = 0; i < total; i++) begin
      if (noise) begin
        start = 1'($urandom); load = 1'($urandom);
        pat_in = LEN'($urandom); reps = 4'($urandom);
      end
      tick();
    end
    clear_noise();
    if (stop_after >= 0) begin
      stop = 1;
      tick();
      stop = 0;
      check("stop_valid", int'(valid), 0);
      check("stop_busy", int'(busy), 0);
      check("stop_z", int'(z), 0);
      check("stop_idx", int'(idx), 0);
      check("stop_no_done", int'(done), 0);
    end else begin
      tick();
      check("fin_done", int'(done), 1);
      check("fin_busy", int'(busy), 0);
    end
  endtask

  task automatic do_load(input logic [LEN-1:0] p);
    pat_in = p; load = 1;
    tick();
    load = 0;
    pat_m = p;
  endtask

  task automatic idle_stop_noise(input int n);
    for (int i = 0; i < n; i++) begin
      stop = 1'($urandom);
      tick();
      check("idle_busy", int'(busy), 0);
      check("idle_valid", int'(valid), 0);
    end
    stop = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    rst_n = 0; clear_noise(); pat_in = '0; reps = '0;
    pat_m = PAT;
    repeat (3) tick();
    check("rst_z", int'(z), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_idx", int'(idx), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1;
    mon_en = 1;
    tick();

    // Single pass of the default pattern, then DONE must clear.
    play(1, -1, 0);
    tick();
    check("done_clears", int'(done), 0);

    // Two passes, then a back-to-back start during the DONE cycle.
    play(2, -1, 0);
    play(1, -1, 0);
    tick();

    // Load alternating pattern and play it; LOAD+START loads without starting.
    do_load(10'b1010101010);
    play(1, -1, 0);
    tick();
    pat_in = 10'b0011100101; load = 1; start = 1; reps = 4'd1;
    tick();
    clear_noise();
    pat_m = 10'b0011100101;
    check("load_start_no_run", int'(busy), 0);
    tick();
    check("load_start_no_valid", int'(valid), 0);
    play(1, -1, 1);   // LOAD/START noise mid-run must not alter the stream
    tick();

    // Continuous mode stopped after 25 bits.
    play(0, 25, 1);
    tick();

    // Reset during bit 5 of a run restores the default pattern.
    do_load(10'b0110011110);
    k = cyc + 1;
    reps = 4'd3; start = 1;
    tick();
    start = 0;
    push_bits(k, 5);
    repeat (5) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    pat_m = PAT;
    check("midrst_z", int'(z), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_idx", int'(idx), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    tick();
    check("midrst_no_done", int'(done), 0);
    play(1, -1, 0);
    tick();

    // STOP in IDLE is ignored.
    idle_stop_noise(4);

    // Randomized runs.
    for (int t = 0; t < 14; t++) begin
      int r, sa;
      if ($urandom_range(0, 2) == 0) do_load(LEN'($urandom));
      r = $urandom_range(0, 4);
      if (r == 0) sa = $urandom_range(1, 30);
      else if ($urandom_range(0, 2) == 0) sa = $urandom_range(1, LEN * r - 1);
      else sa = -1;
      play(r, sa, 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_stop_noise($urandom_range(1, 3));
    end

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
